fsk_mod: RTL and testbench
==========================

FSK_MOD -- requirements
Module: fsk_mod

Interface
REQ-001 SHALL have parameter PHASE_W, default 16, phase-accumulator width in bits (minimum 9).
REQ-002 SHALL have parameter INC0, default 1024, phase increment per sample for a 0 bit (space tone).
REQ-003 SHALL have parameter INC1, default 2048, phase increment per sample for a 1 bit (mark tone).
REQ-004 SHALL have parameter SPB, default 64, samples per bit (range 2..65535).
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port bit_in  input  1  data bit to modulate.
REQ-008 SHALL have port bit_valid  input  1  bit_in is valid.
REQ-009 SHALL have port bit_ready  output  1  block accepts bit_in this cycle.
REQ-010 SHALL have port data_out  output  8  unsigned offset-binary sine sample, mid-scale 128, feeding the FSK demodulator's data_in.
REQ-011 SHALL have port sample_valid  output  1  data_out holds a modulated sample.
REQ-012 SHALL have port busy  output  1  high while in state SEND.

Function
REQ-013 SHALL implement states IDLE and SEND; busy = (state==SEND).
REQ-014 SHALL hold PHASE_W-bit accumulator acc, a sample counter cnt (0..SPB) and a current-bit register cur.
REQ-015 SHALL drive bit_ready = (state==IDLE) or (state==SEND and cnt==SPB), combinationally from registered state only, with no dependence on bit_valid.
REQ-016 SHALL accept a bit on any edge where bit_valid and bit_ready are both high. On that edge: cur<=bit_in, data_out<=SIN(acc), acc<=acc+INC(bit_in), cnt<=1, sample_valid<=1, state<=SEND.
REQ-017 SHALL define SIN(a) = 128 + round(127*sin(2*pi*p/256)), where p = a[PHASE_W-1:PHASE_W-8]. Output range is 1..255. Full-table or quarter-wave-symmetric lookup is allowed, provided results are bit-exact.
REQ-018 SHALL, in SEND with cnt<SPB, emit one sample per clock: data_out<=SIN(acc), acc<=acc+INC(cur), cnt<=cnt+1, sample_valid<=1.
REQ-019 SHALL, in SEND with cnt==SPB and bit_valid high, accept the next bit per REQ-016 with no gap sample. acc is not cleared, so the phase is continuous (CPFSK).
REQ-020 SHALL, in SEND with cnt==SPB and bit_valid low, on that edge go to IDLE and set acc<=0, cnt<=0, data_out<=128, sample_valid<=0.
REQ-021 SHALL wrap acc modulo 2^PHASE_W with no saturation.
REQ-022 SHALL keep all outputs constant in IDLE: data_out=128, sample_valid=0, bit_ready=1.
REQ-023 SHALL emit exactly SPB consecutive samples per accepted bit, with sample_valid high for each one. First-sample latency is 1 clock after the accept edge.
REQ-024 SHALL ignore bit_in and bit_valid whenever bit_ready is low.

Reset
REQ-025 SHALL, while rst is high and independent of clk, force state=IDLE, acc=0, cnt=0, cur=0, data_out=128, sample_valid=0 and busy=0; bit_ready therefore reads 1.
REQ-026 SHALL abandon any bit in progress on reset mid-operation, with no further samples. The first accept after rst deasserts restarts at acc=0.

Verification
REQ-027 SHALL verify reset: assert rst mid-SEND between clock edges -> data_out=128, sample_valid=0, busy=0 and bit_ready=1 immediately, without waiting for a clk edge.
REQ-028 SHALL verify a single bit: with defaults, accept bit 0 at edge 0 -> sample_valid high for edges 1..64 only. Sample n uses p=4*(n-1): sample 1=128, sample 17=255, sample 33=128, sample 49=1. Then IDLE with data_out=128.
REQ-029 SHALL verify a single mark bit: accept bit 1 -> p steps by 8. Sample 9=255, sample 25=1; 64 samples span two full tone cycles.
REQ-030 SHALL verify back-to-back bits 0,1 with bit_valid held high -> bit_ready high only at the cycle with cnt==64, 128 contiguous samples, no gap. Sample 65 uses p=0 (continuous phase after 64*1024 wrap), and sample 66 uses p=8.
REQ-031 SHALL verify handshake: bit_valid asserted while bit_ready=0, with bit_in toggling -> no effect on the current bit's samples. The bit present when bit_ready rises is the one accepted.
REQ-032 SHALL verify a loopback check: feed data_out into the FSK demodulator with pattern 1,0,1,1,0 -> the demodulator recovers the same pattern. Also check that acc wraps cleanly across more than 2^PHASE_W / INC1 samples.

Source files
------------

// File: rtl/fsk_mod.sv
// Continuous-phase binary FSK modulator: one 8-bit offset-binary sine sample per clock,
// SPB samples per accepted bit, phase carried across bit boundaries.
module fsk_mod #(
    parameter int PHASE_W = 16,
    parameter int INC0    = 1024,
    parameter int INC1    = 2048,
    parameter int SPB     = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic [7:0] data_out,
    output logic       sample_valid,
    output logic       busy
);

    localparam int                 CNT_W  = $clog2(SPB + 1);
    localparam logic [PHASE_W-1:0] INC0_V = PHASE_W'(INC0);
    localparam logic [PHASE_W-1:0] INC1_V = PHASE_W'(INC1);
    localparam logic [CNT_W-1:0]   SPB_V  = CNT_W'(SPB);
    localparam logic [CNT_W-1:0]   ONE_V  = CNT_W'(1'b1);
    localparam logic [7:0]         MID    = 8'd128;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [PHASE_W-1:0] acc_r;
    logic [PHASE_W-1:0] acc_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic               cur_r;
    logic               cur_s;
    logic [7:0]         data_s;
    logic               sv_s;
    logic               at_end_s;
    logic               accept_s;

    // round(127*sin(2*pi*k/256)) for the first quarter wave, k = 0..64
    function automatic logic [6:0] qtr(input logic [6:0] k);
        logic [6:0] q;
        case (k)
            7'd0:  q = 7'd0;
            7'd1:  q = 7'd3;
            7'd2:  q = 7'd6;
            7'd3:  q = 7'd9;
            7'd4:  q = 7'd12;
            7'd5:  q = 7'd16;
            7'd6:  q = 7'd19;
            7'd7:  q = 7'd22;
            7'd8:  q = 7'd25;
            7'd9:  q = 7'd28;
            7'd10: q = 7'd31;
            7'd11: q = 7'd34;
            7'd12: q = 7'd37;
            7'd13: q = 7'd40;
            7'd14: q = 7'd43;
            7'd15: q = 7'd46;
            7'd16: q = 7'd49;
            7'd17: q = 7'd51;
            7'd18: q = 7'd54;
            7'd19: q = 7'd57;
            7'd20: q = 7'd60;
            7'd21: q = 7'd63;
            7'd22: q = 7'd65;
            7'd23: q = 7'd68;
            7'd24: q = 7'd71;
            7'd25: q = 7'd73;
            7'd26: q = 7'd76;
            7'd27: q = 7'd78;
            7'd28: q = 7'd81;
            7'd29: q = 7'd83;
            7'd30: q = 7'd85;
            7'd31: q = 7'd88;
            7'd32: q = 7'd90;
            7'd33: q = 7'd92;
            7'd34: q = 7'd94;
            7'd35: q = 7'd96;
            7'd36: q = 7'd98;
            7'd37: q = 7'd100;
            7'd38: q = 7'd102;
            7'd39: q = 7'd104;
            7'd40: q = 7'd106;
            7'd41: q = 7'd107;
            7'd42: q = 7'd109;
            7'd43: q = 7'd111;
            7'd44: q = 7'd112;
            7'd45: q = 7'd113;
            7'd46: q = 7'd115;
            7'd47: q = 7'd116;
            7'd48: q = 7'd117;
            7'd49: q = 7'd118;
            7'd50: q = 7'd120;
            7'd51: q = 7'd121;
            7'd52: q = 7'd122;
            7'd53: q = 7'd122;
            7'd54: q = 7'd123;
            7'd55: q = 7'd124;
            7'd56: q = 7'd125;
            7'd57: q = 7'd125;
            7'd58: q = 7'd126;
            7'd59: q = 7'd126;
            7'd60: q = 7'd126;
            7'd61: q = 7'd127;
            7'd62: q = 7'd127;
            7'd63: q = 7'd127;
            7'd64: q = 7'd127;
            default: q = 7'd0;
        endcase
        return q;
    endfunction

    // Full-wave sample from the quarter table: mirror in quadrants 1/3, negate in 2/3
    function automatic logic [7:0] sin_lut(input logic [7:0] p);
        logic [6:0] k;
        logic [6:0] m;
        case (p[7:6])
            2'd0:    k = {1'b0, p[5:0]};
            2'd1:    k = 7'd64 - {1'b0, p[5:0]};
            2'd2:    k = {1'b0, p[5:0]};
            2'd3:    k = 7'd64 - {1'b0, p[5:0]};
            default: k = 7'd0;
        endcase
        m = qtr(k);
        if (p[7]) begin
            return MID - {1'b0, m};
        end else begin
            return MID + {1'b0, m};
        end
    endfunction

    function automatic logic [PHASE_W-1:0] inc_of(input logic b);
        if (b) begin
            return INC1_V;
        end else begin
            return INC0_V;
        end
    endfunction

    assign at_end_s = (cnt_r == SPB_V);
    assign accept_s = bit_valid & bit_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: leave SEND only at the end of a bit with no follow-on bit offered
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bit_valid) begin
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (at_end_s && !bit_valid) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SEND;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Handshake/status outputs, decoded from registered state only
    always_comb begin
        bit_ready = 1'b1;
        busy      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                bit_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_SEND: begin
                bit_ready = at_end_s;
                busy      = 1'b1;
            end
            default: begin
                bit_ready = 1'b1;
                busy      = 1'b0;
            end
        endcase
    end

    // Datapath next values; the sample emitted uses the phase before this cycle's increment
    always_comb begin
        acc_s  = acc_r;
        cnt_s  = cnt_r;
        cur_s  = cur_r;
        data_s = data_out;
        sv_s   = sample_valid;
        if (accept_s) begin
            cur_s  = bit_in;
            data_s = sin_lut(acc_r[PHASE_W-1 -: 8]);
            acc_s  = acc_r + inc_of(bit_in);
            cnt_s  = ONE_V;
            sv_s   = 1'b1;
        end else if ((state_r == ST_SEND) && !at_end_s) begin
            data_s = sin_lut(acc_r[PHASE_W-1 -: 8]);
            acc_s  = acc_r + inc_of(cur_r);
            cnt_s  = cnt_r + ONE_V;
            sv_s   = 1'b1;
        end else if (state_r == ST_SEND) begin
            acc_s  = {PHASE_W{1'b0}};
            cnt_s  = {CNT_W{1'b0}};
            data_s = MID;
            sv_s   = 1'b0;
        end else begin
            data_s = MID;
            sv_s   = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r        <= {PHASE_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            cur_r        <= 1'b0;
            data_out     <= MID;
            sample_valid <= 1'b0;
        end else begin
            acc_r        <= acc_s;
            cnt_r        <= cnt_s;
            cur_r        <= cur_s;
            data_out     <= data_s;
            sample_valid <= sv_s;
        end
    end

endmodule

// File: tb/tb_fsk_mod.sv
// Directed self-checking bench for fsk_mod with default parameters.
module tb_fsk_mod;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic [7:0] data_out;
    logic       sample_valid;
    logic       busy;

    fsk_mod dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .data_out    (data_out),
        .sample_valid(sample_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bits;   // bits[0] sent first
        int         nbits;
        int         idx;    // 1-based sample number
        int         exp;
    } vec_t;

    vec_t       vecs [15];
    logic [7:0] samp [512];
    int         nsamp;
    int         gaps;
    int         rb_cnt;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Offers bits back-to-back; bit_in toggles garbage whenever bit_ready is low.
    // Must be entered just after a falling edge with the DUT idle.
    task automatic run_bits(input logic [7:0] bits, input int nbits);
        int idx = 0;
        int cyc = 0;
        bit started = 1'b0;
        bit done = 1'b0;
        nsamp = 0;
        gaps = 0;
        rb_cnt = 0;
        while (!done && cyc < 2000) begin
            if (bit_ready && idx < nbits) begin
                bit_valid = 1'b1;
                bit_in = bits[idx];
                idx++;
            end else if (idx < nbits) begin
                bit_valid = 1'b1;
                bit_in = cyc[0];
            end else begin
                bit_valid = 1'b0;
                bit_in = cyc[0];
            end
            @(negedge clk);
            cyc++;
            if (sample_valid) begin
                if (nsamp < 512) samp[nsamp] = data_out;
                nsamp++;
                started = 1'b1;
            end else if (started && busy) begin
                gaps++;
            end
            if (busy && bit_ready) rb_cnt++;
            if (started && !busy && !sample_valid) done = 1'b1;
        end
        bit_valid = 1'b0;
        check("run_completes", int'(done), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int demod [5];
        int trans;
        rst = 1'b1;
        bit_in = 1'b0;
        bit_valid = 1'b0;

        vecs[0]  = '{8'h00, 1, 1,  128};
        vecs[1]  = '{8'h00, 1, 5,  177};
        vecs[2]  = '{8'h00, 1, 9,  218};
        vecs[3]  = '{8'h00, 1, 17, 255};
        vecs[4]  = '{8'h00, 1, 33, 128};
        vecs[5]  = '{8'h00, 1, 49, 1};
        vecs[6]  = '{8'h00, 1, 64, 116};
        vecs[7]  = '{8'h01, 1, 2,  153};
        vecs[8]  = '{8'h01, 1, 9,  255};
        vecs[9]  = '{8'h01, 1, 25, 1};
        vecs[10] = '{8'h01, 1, 33, 128};
        vecs[11] = '{8'h02, 2, 64, 116};
        vecs[12] = '{8'h02, 2, 65, 128};
        vecs[13] = '{8'h02, 2, 66, 153};
        vecs[14] = '{8'h01 | 8'h00, 2, 66, 140};

        repeat (2) @(negedge clk);
        check("rst_data_out", int'(data_out), 128);
        check("rst_sample_valid", int'(sample_valid), 0);
        check("rst_bit_ready", int'(bit_ready), 1);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;

        // Idle: bit_in wiggles with bit_valid low, outputs stay at rest
        for (int i = 0; i < 4; i++) begin
            bit_in = i[0];
            @(negedge clk);
        end
        check("idle_data_out", int'(data_out), 128);
        check("idle_sample_valid", int'(sample_valid), 0);
        check("idle_busy", int'(busy), 0);

        for (int v = 0; v < 15; v++) begin
            run_bits(vecs[v].bits, vecs[v].nbits);
            check($sformatf("vec%0d_sample%0d", v, vecs[v].idx),
                  int'(samp[vecs[v].idx - 1]), vecs[v].exp);
            check($sformatf("vec%0d_count", v), nsamp, 64 * vecs[v].nbits);
            check($sformatf("vec%0d_gaps", v), gaps, 0);
            check($sformatf("vec%0d_ready_in_send", v), rb_cnt, vecs[v].nbits);
            check($sformatf("vec%0d_idle_data", v), int'(data_out), 128);
        end

        // Asynchronous reset in the middle of a mark bit
        bit_valid = 1'b1;
        bit_in = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", int'(busy), 1);
        check("pre_rst_valid", int'(sample_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_data_out", int'(data_out), 128);
        check("async_rst_sample_valid", int'(sample_valid), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_bit_ready", int'(bit_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_no_samples", int'(sample_valid), 0);
        run_bits(8'h00, 1);
        check("post_rst_sample1", int'(samp[0]), 128);
        check("post_rst_sample17", int'(samp[16]), 255);
        check("post_rst_count", nsamp, 64);

        // Loopback through a zero-crossing FSK detector: pattern 1,0,1,1,0
        run_bits(8'b0000_1101, 5);
        check("loop_count", nsamp, 320);
        for (int b = 0; b < 5; b++) begin
            trans = 0;
            for (int s = 1; s < 64; s++) begin
                if ((samp[b*64 + s] >= 8'd128) != (samp[b*64 + s - 1] >= 8'd128)) trans++;
            end
            demod[b] = (trans >= 3) ? 1 : 0;
        end
        check("loop_bit0", demod[0], 1);
        check("loop_bit1", demod[1], 0);
        check("loop_bit2", demod[2], 1);
        check("loop_bit3", demod[3], 1);
        check("loop_bit4", demod[4], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
